// File: rtl/mult_nxn_fast_if.sv
// -----------------------------------------------------------------------------
// mult_nxn_fast_if
// Request/response bundle for the word-serial N x N multiplier.
//
// Signals (DATA_W = WORD_W*WORDS):
//   start    requester -> multiplier  request, honoured only when not busy
//   a, b     requester -> multiplier  unsigned operands, captured with start
//   busy     multiplier -> requester  high while partial products accumulate
//   done     multiplier -> requester  one-cycle pulse, product valid
//   product  multiplier -> requester  2*DATA_W result register
//
// Modports: master (requester side), slave (multiplier side).
// -----------------------------------------------------------------------------
interface mult_nxn_fast_if #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 2
);
  localparam int DATA_W = WORD_W * WORDS;

  logic                  start;
  logic [DATA_W-1:0]     a;
  logic [DATA_W-1:0]     b;
  logic                  busy;
  logic                  done;
  logic [2*DATA_W-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/mult_nxn_fast.sv
// -----------------------------------------------------------------------------
// mult_nxn_fast
// Unsigned DATA_W x DATA_W multiplier built from one WORD_W x WORD_W
// sub-multiplier. Operands are split into WORDS words; one partial product
// is accumulated per cycle. Word pairs above the highest nonzero word of
// either operand are never visited, so latency is na*nb+1 cycles from the
// start edge to the done pulse (na/nb = number of significant words, min 1).
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high; aborts any operation, no done follows
//   bus    mult_nxn_fast_if.slave: start/a/b in, busy/done/product out
//
// Outputs busy, done and product are all driven straight from registers.
// -----------------------------------------------------------------------------
module mult_nxn_fast #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 2
) (
  input  logic           clk,
  input  logic           reset,
  mult_nxn_fast_if.slave bus
);

  localparam int DATA_W = WORD_W * WORDS;
  localparam int PROD_W = 2 * DATA_W;
  // Word indices run 0..WORDS-1; keep at least one bit for WORDS=1.
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(1'b0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index of the highest nonzero word of v; 0 when v is zero, so a zero
  // operand still costs exactly one (zero) partial product.
  function automatic logic [IDX_W-1:0] top_word_idx(input logic [DATA_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = IDX_ZERO;
    for (int k = 0; k < WORDS; k++) begin
      if (v[k*WORD_W +: WORD_W] != {WORD_W{1'b0}}) begin
        idx = IDX_W'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_e              state_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  // Last word index to visit for each operand (na-1 / nb-1).
  logic [IDX_W-1:0]    a_last_r;
  logic [IDX_W-1:0]    b_last_r;
  logic [IDX_W-1:0]    i_r;
  logic [IDX_W-1:0]    j_r;
  logic                busy_r;
  logic                done_r;
  logic [PROD_W-1:0]   product_r;

  logic [WORD_W-1:0]   word_a_s;
  logic [WORD_W-1:0]   word_b_s;
  logic [2*WORD_W-1:0] pp_s;
  int                  shamt_s;
  logic [PROD_W-1:0]   pp_shift_s;
  logic                last_j_s;
  logic                last_pair_s;

  // Current partial product, aligned to its weight WORD_W*(i+j).
  always_comb begin
    word_a_s    = a_r[i_r*WORD_W +: WORD_W];
    word_b_s    = b_r[j_r*WORD_W +: WORD_W];
    pp_s        = {{WORD_W{1'b0}}, word_a_s} * {{WORD_W{1'b0}}, word_b_s};
    shamt_s     = WORD_W * (int'(i_r) + int'(j_r));
    pp_shift_s  = PROD_W'(pp_s) << shamt_s;
    last_j_s    = (j_r == b_last_r);
    last_pair_s = last_j_s && (i_r == a_last_r);
  end

  // Control FSM and accumulator; all outputs registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      a_r       <= {DATA_W{1'b0}};
      b_r       <= {DATA_W{1'b0}};
      a_last_r  <= IDX_ZERO;
      b_last_r  <= IDX_ZERO;
      i_r       <= IDX_ZERO;
      j_r       <= IDX_ZERO;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {PROD_W{1'b0}};
    end else begin
      case (state_r)
        // IDLE and DONE accept a new request identically, which gives
        // back-to-back operation without an idle bubble.
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            a_last_r <= top_word_idx(bus.a);
            b_last_r <= top_word_idx(bus.b);
            i_r      <= IDX_ZERO;
            j_r      <= IDX_ZERO;
            busy_r   <= 1'b1;
            state_r  <= ST_CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        ST_CALC: begin
          // First pair overwrites the old result instead of adding to it.
          if ((i_r == IDX_ZERO) && (j_r == IDX_ZERO)) begin
            product_r <= pp_shift_s;
          end else begin
            product_r <= product_r + pp_shift_s;
          end

          if (last_pair_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (last_j_s) begin
            j_r <= IDX_ZERO;
            i_r <= i_r + IDX_ONE;
          end else begin
            j_r <= j_r + IDX_ONE;
          end
        end

        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_mult_nxn_fast.sv
// -----------------------------------------------------------------------------
// tb_mult_nxn_fast
// Two instances: 16x2 words (directed cases) and 8x4 words (random cases).
// Expected products come from plain 64-bit multiplication; expected latency
// from counting significant words arithmetically.
// -----------------------------------------------------------------------------
module tb_mult_nxn_fast;

  logic clk;
  logic reset;

  int n_cmp;
  int n_mis;

  mult_nxn_fast_if #(.WORD_W(16), .WORDS(2)) if16 ();
  mult_nxn_fast_if #(.WORD_W(8),  .WORDS(4)) if8 ();

  mult_nxn_fast #(.WORD_W(16), .WORDS(2)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (if16)
  );

  mult_nxn_fast #(.WORD_W(8), .WORDS(4)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Number of significant words of v (1 for zero).
  function automatic int sig_words(input logic [31:0] v, input int w);
    int n;
    n = 1;
    for (int k = 1; k * w < 32; k++) begin
      if ((v >> (k * w)) != 32'd0) n = k + 1;
    end
    return n;
  endfunction

  task automatic drive(input bit use8, input logic st, input logic [31:0] av, input logic [31:0] bv);
    if (use8) begin
      if8.start = st; if8.a = av; if8.b = bv;
    end else begin
      if16.start = st; if16.a = av; if16.b = bv;
    end
  endtask

  // Issue one request at the current negedge; return latency counted from
  // the start edge (inclusive) to the done cycle, busy cycles and product.
  // When glitch>0, start is re-pulsed with other operands during CALC.
  task automatic run_op(input bit use8, input logic [31:0] av, input logic [31:0] bv,
                        input int glitch, output int lat, output int busy_n,
                        output logic [63:0] prod);
    bit got;
    logic d, bz;
    got = 1'b0;
    busy_n = 0;
    drive(use8, 1'b1, av, bv);
    @(posedge clk);
    lat = 1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= glitch) drive(use8, 1'b1, 32'h0000_0002, 32'h0000_0003);
      else drive(use8, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      d  = use8 ? if8.done : if16.done;
      bz = use8 ? if8.busy : if16.busy;
      if (d) begin
        got = 1'b1;
      end else begin
        if (bz) busy_n++;
        @(posedge clk);
        lat++;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    prod = use8 ? if8.product : if16.product;
  endtask

  task automatic directed(input logic [31:0] av, input logic [31:0] bv, input string tag);
    int lat, bn, nn;
    logic [63:0] p;
    nn = sig_words(av, 16) * sig_words(bv, 16);
    run_op(1'b0, av, bv, 0, lat, bn, p);
    chk({tag, "_prod"}, p, {32'd0, av} * {32'd0, bv});
    chk({tag, "_lat"}, 64'(lat), 64'(nn + 1));
    chk({tag, "_busy"}, 64'(bn), 64'(nn));
  endtask

  initial begin
    int lat, bn, seen;
    logic [63:0] p;
    logic [31:0] ra, rb;
    n_cmp = 0;
    n_mis = 0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy16", 64'(if16.busy), 64'd0);
    chk("rst_done16", 64'(if16.done), 64'd0);
    chk("rst_prod16", if16.product, 64'd0);
    chk("rst_busy8", 64'(if8.busy), 64'd0);
    chk("rst_done8", 64'(if8.done), 64'd0);
    chk("rst_prod8", if8.product, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Smallest case, then confirm done is a single-cycle pulse.
    directed(32'h0000_0003, 32'h0000_0005, "small");
    @(negedge clk);
    chk("done_pulse", 64'(if16.done), 64'd0);
    chk("hold_prod", if16.product, 64'h0000_0000_0000_000F);

    directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones");
    chk("ones_const", if16.product, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    directed(32'h0000_0000, 32'h1234_5678, "zero_a");

    // Back-to-back: the second request is issued in the DONE cycle.
    @(negedge clk);
    directed(32'h0001_0000, 32'h0000_0007, "na2nb1");
    directed(32'h0002_0000, 32'h0003_0000, "b2b");
    chk("b2b_const", if16.product, 64'h0000_0006_0000_0000);

    // start during CALC with other operands must be ignored.
    @(negedge clk);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, lat, bn, p);
    chk("ignore_prod", p, 64'hFFFF_FFFE_0000_0001);
    chk("ignore_lat", 64'(lat), 64'd5);
    @(negedge clk);

    // Reset in the second CALC cycle aborts with no done.
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 64'(if16.busy), 64'd0);
    chk("abort_done", 64'(if16.done), 64'd0);
    chk("abort_prod", if16.product, 64'd0);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if16.done || if16.busy) seen++;
    end
    chk("abort_quiet", 64'(seen), 64'd0);
    directed(32'h0000_0003, 32'h0000_0005, "after_rst");
    @(negedge clk);

    // 8x4 instance: randomized operands, mixed magnitude classes.
    for (int n = 0; n < 1200; n++) begin
      logic [31:0] v [2];
      for (int s = 0; s < 2; s++) begin
        case ($urandom_range(0, 4))
          0: v[s] = 32'd0;
          1: v[s] = 32'hFFFF_FFFF;
          2: v[s] = 32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3));
          3: v[s] = $urandom;
          default: v[s] = $urandom >> (8 * $urandom_range(0, 3));
        endcase
      end
      ra = (n == 0) ? 32'd0 : (n == 1) ? 32'hFFFF_FFFF : v[0];
      rb = (n == 0) ? 32'd0 : (n == 1) ? 32'hFFFF_FFFF : v[1];
      run_op(1'b1, ra, rb, 0, lat, bn, p);
      chk("rand_prod", p, {32'd0, ra} * {32'd0, rb});
      chk("rand_lat", 64'(lat), 64'(sig_words(ra, 8) * sig_words(rb, 8) + 1));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
